memc_dma_port: RTL and testbench

MEMC_DMA_PORT -- requirements
Module: memc_dma_port

---
 rtl/memc_dma_port.sv | 142 ++++++++++++++
 tb/tb_memc_dma_port.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memc_dma_port.sv
// memc_dma_port: arbitrates DMA read/write requests onto one single-port SRAM and
//   returns read data through a small in-order FIFO.
// Latency: writes reach the SRAM in the acceptance cycle; read data is offered 2 cycles
//   after acceptance when the FIFO is empty and read_pause is low.
// Backpressure: read_ready drops once queued plus in-flight reads would fill the FIFO;
//   read_pause stalls only the return path, so writes keep flowing at full rate.
// Ports: clk / reset_poweron (sync, active high); dma__memc__write_* and memc__dma__write_ready
//   form the write request; dma__memc__read_* and memc__dma__read_ready form the read request;
//   dma__memc__read_pause, memc__dma__read_data(_valid) form the return path;
//   memc__sram__* and sram__memc__rdata connect the single-port SRAM.
module memc_dma_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 24,
  parameter int RD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              dma__memc__write_valid,
  input  logic [ADDR_W-1:0] dma__memc__write_address,
  input  logic [DATA_W-1:0] dma__memc__write_data,
  output logic              memc__dma__write_ready,
  input  logic              dma__memc__read_valid,
  input  logic [ADDR_W-1:0] dma__memc__read_address,
  output logic              memc__dma__read_ready,
  input  logic              dma__memc__read_pause,
  output logic [DATA_W-1:0] memc__dma__read_data,
  output logic              memc__dma__read_data_valid,
  output logic              memc__sram__en,
  output logic              memc__sram__we,
  output logic [ADDR_W-1:0] memc__sram__addr,
  output logic [DATA_W-1:0] memc__sram__wdata,
  input  logic [DATA_W-1:0] sram__memc__rdata
);

  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RD_DEPTH);

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

  gnt_e              last_gnt_q, last_gnt_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] fifo_mem_q [RD_DEPTH];

  logic [OCC_W-1:0]  occupancy;
  logic              rd_ok;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              push;
  logic              pop;

  // Arbitration. Occupancy counts every read already accepted but not yet
  // handed back, so a new read is only taken when its data is sure to fit.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    rd_ok     = occupancy < DEPTH_OCC;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    if (!reset_poweron) begin
      // A read wins a contested cycle only if the previous grant went to a write.
      rd_gnt = dma__memc__read_valid && rd_ok &&
               (!dma__memc__write_valid || (last_gnt_q == GNT_WR));
      wr_gnt = dma__memc__write_valid && !rd_gnt;
    end
  end

  assign memc__dma__write_ready = wr_gnt;
  assign memc__dma__read_ready  = rd_gnt;

  // SRAM drive: unpipelined, and held at zero in idle cycles.
  always_comb begin
    memc__sram__en    = wr_gnt | rd_gnt;
    memc__sram__we    = wr_gnt;
    memc__sram__addr  = '0;
    memc__sram__wdata = '0;
    if (wr_gnt) begin
      memc__sram__addr  = dma__memc__write_address;
      memc__sram__wdata = dma__memc__write_data;
    end else if (rd_gnt) begin
      memc__sram__addr  = dma__memc__read_address;
    end
  end

  // Return FIFO. SRAM data is valid the cycle after the read was issued, which
  // is exactly when inflight_q is set.
  always_comb begin
    push = inflight_q;
    pop  = !reset_poweron && (count_q != '0) && !dma__memc__read_pause;

    last_gnt_d = last_gnt_q;
    if (rd_gnt) begin
      last_gnt_d = GNT_RD;
    end else if (wr_gnt) begin
      last_gnt_d = GNT_WR;
    end

    inflight_d = rd_gnt;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign memc__dma__read_data_valid = pop;
  assign memc__dma__read_data       = reset_poweron ? '0 : fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      last_gnt_q <= GNT_WR;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible after it has been pushed.
  // A read still in flight when reset arrives is dropped here.
  always_ff @(posedge clk) begin
    if (push && !reset_poweron) begin
      fifo_mem_q[wr_ptr_q] <= sram__memc__rdata;
    end
  end

endmodule

// File: tb/tb_memc_dma_port.sv
module tb_memc_dma_port;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 24;
  localparam int RD_DEPTH = 4;
  localparam int OUTS_W   = 5 + ADDR_W + 2 * DATA_W;

  logic              clk = 1'b0;
  logic              reset_poweron;
  logic              wr_vld, rd_vld, pause;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_rdy, rd_rdy, rd_dv;
  logic [DATA_W-1:0] rd_data;
  logic              sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memc_dma_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_DEPTH(RD_DEPTH)) dut (
    .clk                        (clk),
    .reset_poweron              (reset_poweron),
    .dma__memc__write_valid     (wr_vld),
    .dma__memc__write_address   (wr_addr),
    .dma__memc__write_data      (wr_data),
    .memc__dma__write_ready     (wr_rdy),
    .dma__memc__read_valid      (rd_vld),
    .dma__memc__read_address    (rd_addr),
    .memc__dma__read_ready      (rd_rdy),
    .dma__memc__read_pause      (pause),
    .memc__dma__read_data       (rd_data),
    .memc__dma__read_data_valid (rd_dv),
    .memc__sram__en             (sram_en),
    .memc__sram__we             (sram_we),
    .memc__sram__addr           (sram_addr),
    .memc__sram__wdata          (sram_wdata),
    .sram__memc__rdata          (sram_rdata)
  );

  // Unwritten locations read back as a recognisable address-derived pattern.
  function automatic logic [DATA_W-1:0] fill_pattern(input logic [ADDR_W-1:0] a);
    return {8'hD0, a};
  endfunction

  // Single-port SRAM with one cycle of read latency.
  logic [DATA_W-1:0] sram_mem [logic [ADDR_W-1:0]];
  always @(posedge clk) begin
    if (sram_en === 1'b1) begin
      if (sram_we === 1'b1) sram_mem[sram_addr] = sram_wdata;
      else if (sram_mem.exists(sram_addr)) sram_rdata <= sram_mem[sram_addr];
      else sram_rdata <= fill_pattern(sram_addr);
    end
  end

  // Reference model: a queue of accepted-but-undelivered reads, each carrying
  // its expected data and acceptance cycle, plus a shadow copy of memory.
  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } rd_ent_t;

  rd_ent_t           oq[$];
  logic [DATA_W-1:0] shadow [logic [ADDR_W-1:0]];
  bit                m_last_rd = 1'b0;
  int                m_cyc     = 0;

  function automatic void predict(output bit wg, output bit rg, output bit dv);
    wg = 1'b0;
    rg = 1'b0;
    dv = 1'b0;
    if (reset_poweron !== 1'b1) begin
      rg = (rd_vld === 1'b1) && (oq.size() < RD_DEPTH) && ((wr_vld !== 1'b1) || !m_last_rd);
      wg = (wr_vld === 1'b1) && !rg;
      if ((oq.size() > 0) && (pause !== 1'b1)) begin
        if (oq[0].cyc + 2 <= m_cyc) dv = 1'b1;
      end
    end
  endfunction

  always @(posedge clk) begin : model_update
    bit      wg, rg, dv;
    rd_ent_t e;
    predict(wg, rg, dv);
    if (reset_poweron === 1'b1) begin
      oq.delete();
      m_last_rd = 1'b0;
    end else begin
      if (dv) void'(oq.pop_front());
      if (wg) begin
        shadow[wr_addr] = wr_data;
        m_last_rd = 1'b0;
      end
      if (rg) begin
        e.data = shadow.exists(rd_addr) ? shadow[rd_addr] : fill_pattern(rd_addr);
        e.cyc  = m_cyc;
        oq.push_back(e);
        m_last_rd = 1'b1;
      end
    end
    m_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_vld = 1'b0;
    rd_vld = 1'b0;
    pause  = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    logic [OUTS_W-1:0] outs;
    reset_poweron = 1'b1;
    wr_vld = 1'b1; rd_vld = 1'b1; pause = 1'b0;
    wr_addr = 24'h5; rd_addr = 24'h6; wr_data = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {wr_rdy, rd_rdy, rd_dv, sram_en, sram_we, sram_addr, sram_wdata, rd_data};
      checks++;
      if (outs !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got %h, expected all zero", i, outs);
      end
      step();
    end
    reset_poweron = 1'b0;
    rd_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0 || sram_en !== 1'b1 || sram_we !== 1'b1 ||
        sram_addr !== 24'h5) begin
      failures++;
      $display("FAIL first_cycle_accept: got wr_rdy=%b rd_rdy=%b en=%b we=%b addr=%h, expected 1 0 1 1 000005",
               wr_rdy, rd_rdy, sram_en, sram_we, sram_addr);
    end
    step();
    idle(1);
  endtask

  task automatic test_write_read();
    wr_vld = 1'b1; wr_addr = 24'h10; wr_data = 32'h3F80_0000;
    @(negedge clk);
    checks++;
    if (wr_rdy !== 1'b1 || sram_en !== 1'b1 || sram_we !== 1'b1 ||
        sram_addr !== 24'h10 || sram_wdata !== 32'h3F80_0000) begin
      failures++;
      $display("FAIL wr_issue: got rdy=%b en=%b we=%b addr=%h wdata=%h, expected 1 1 1 000010 3f800000",
               wr_rdy, sram_en, sram_we, sram_addr, sram_wdata);
    end
    step();
    wr_vld = 1'b0; rd_vld = 1'b1; rd_addr = 24'h10;
    @(negedge clk);
    checks++;
    if (rd_rdy !== 1'b1 || sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 24'h10) begin
      failures++;
      $display("FAIL rd_issue: got rdy=%b en=%b we=%b addr=%h, expected 1 1 0 000010",
               rd_rdy, sram_en, sram_we, sram_addr);
    end
    step();
    rd_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_dv !== 1'b0) begin
      failures++;
      $display("FAIL rd_latency_n1: got valid=%b, expected 0", rd_dv);
    end
    step();
    @(negedge clk);
    checks++;
    if (rd_dv !== 1'b1 || rd_data !== 32'h3F80_0000) begin
      failures++;
      $display("FAIL rd_latency_n2: got valid=%b data=%h, expected 1 3f800000", rd_dv, rd_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (rd_dv !== 1'b0) begin
      failures++;
      $display("FAIL rd_single_beat: got valid=%b, expected 0", rd_dv);
    end
    step();
  endtask

  task automatic test_alternate();
    int nw = 0;
    int nr = 0;
    bit exp_rd;
    reset_poweron = 1'b1;
    idle(2);
    reset_poweron = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_vld = 1'b1; rd_vld = 1'b1;
      wr_addr = 24'h200 + ADDR_W'(i);
      rd_addr = 24'h300 + ADDR_W'(i);
      wr_data = $urandom;
      exp_rd = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (rd_rdy !== exp_rd || wr_rdy !== !exp_rd) begin
        failures++;
        $display("FAIL alt_grant cycle %0d: got wr=%b rd=%b, expected wr=%b rd=%b",
                 i, wr_rdy, rd_rdy, !exp_rd, exp_rd);
      end
      if (wr_rdy === 1'b1) nw++;
      if (rd_rdy === 1'b1) nr++;
      step();
    end
    checks++;
    if (nw != 4 || nr != 4) begin
      failures++;
      $display("FAIL alt_counts: got writes=%0d reads=%0d, expected 4 4", nw, nr);
    end
    idle(4);
  endtask

  task automatic test_pause();
    int acc = 0;
    bit exp_rdy;
    for (int i = 0; i < 8; i++) begin
      wr_vld  = 1'b1;
      wr_addr = 24'h400 + ADDR_W'(i);
      wr_data = 32'hA500_0000 + DATA_W'(i);
      step();
    end
    wr_vld = 1'b0; pause = 1'b1; rd_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 24'h400 + ADDR_W'(acc);
      exp_rdy = (i < RD_DEPTH);
      @(negedge clk);
      checks++;
      if (rd_rdy !== exp_rdy || rd_dv !== 1'b0) begin
        failures++;
        $display("FAIL pause_accept cycle %0d: got rdy=%b valid=%b, expected %b 0",
                 i, rd_rdy, rd_dv, exp_rdy);
      end
      if (rd_rdy === 1'b1) acc++;
      step();
    end
    pause = 1'b0; rd_vld = 1'b0;
    for (int k = 0; k < RD_DEPTH; k++) begin
      @(negedge clk);
      checks++;
      if (rd_dv !== 1'b1 || rd_data !== 32'hA500_0000 + DATA_W'(k)) begin
        failures++;
        $display("FAIL pause_beat %0d: got valid=%b data=%h, expected 1 %h",
                 k, rd_dv, rd_data, 32'hA500_0000 + DATA_W'(k));
      end
      step();
    end
    rd_vld = 1'b1; rd_addr = 24'h404;
    @(negedge clk);
    checks++;
    if (rd_dv !== 1'b0 || rd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL pause_ready_back: got valid=%b rdy=%b, expected 0 1", rd_dv, rd_rdy);
    end
    step();
    idle(4);
  endtask

  task automatic test_wrap();
    int acc   = 0;
    int beats = 0;
    logic [DATA_W-1:0] exp_d;
    for (int i = 0; i < 24; i++) begin
      pause   = (i < RD_DEPTH);
      rd_vld  = (i < 16);
      rd_addr = 24'h400 + ADDR_W'(acc % 8);
      @(negedge clk);
      if (i == RD_DEPTH) begin
        checks++;
        if (rd_rdy !== 1'b0) begin
          failures++;
          $display("FAIL wrap_full_ready: got rdy=%b, expected 0", rd_rdy);
        end
      end
      if (rd_dv === 1'b1) begin
        exp_d = 32'hA500_0000 + DATA_W'(beats % 8);
        checks++;
        if (rd_data !== exp_d) begin
          failures++;
          $display("FAIL wrap_data beat %0d: got %h, expected %h", beats, rd_data, exp_d);
        end
        beats++;
      end
      if (rd_rdy === 1'b1) acc++;
      step();
    end
    checks++;
    if (acc != 15 || beats != 15) begin
      failures++;
      $display("FAIL wrap_count: got accepted=%0d beats=%0d, expected 15 15", acc, beats);
    end
    idle(2);
  endtask

  task automatic test_reset_inflight();
    logic [OUTS_W-1:0] outs;
    rd_vld = 1'b1; rd_addr = 24'h401;
    @(negedge clk);
    checks++;
    if (rd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL inflight_accept: got rdy=%b, expected 1", rd_rdy);
    end
    step();
    rd_vld = 1'b0;
    reset_poweron = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      outs = {wr_rdy, rd_rdy, rd_dv, sram_en, sram_we, sram_addr, sram_wdata, rd_data};
      checks++;
      if (outs !== '0) begin
        failures++;
        $display("FAIL inflight_reset_outputs cycle %0d: got %h, expected all zero", i, outs);
      end
      step();
    end
    reset_poweron = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rd_dv !== 1'b0) begin
        failures++;
        $display("FAIL inflight_discard cycle %0d: got valid=%b, expected 0", i, rd_dv);
      end
      step();
    end
  endtask

  task automatic test_pause_writes();
    int nw = 0;
    pause = 1'b1; rd_vld = 1'b1;
    for (int i = 0; i < RD_DEPTH; i++) begin
      rd_addr = 24'h400 + ADDR_W'(i);
      step();
    end
    wr_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_addr = 24'h500 + ADDR_W'(i);
      wr_data = $urandom;
      @(negedge clk);
      checks++;
      if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0 || sram_en !== 1'b1 || sram_we !== 1'b1 ||
          sram_addr !== wr_addr || sram_wdata !== wr_data) begin
        failures++;
        $display("FAIL pause_write cycle %0d: got wr=%b rd=%b en=%b we=%b addr=%h, expected 1 0 1 1 %h",
                 i, wr_rdy, rd_rdy, sram_en, sram_we, sram_addr, wr_addr);
      end
      if (sram_en === 1'b1 && sram_we === 1'b1) nw++;
      step();
    end
    checks++;
    if (nw != 20) begin
      failures++;
      $display("FAIL pause_write_count: got %0d, expected 20", nw);
    end
    wr_vld = 1'b0; rd_vld = 1'b0; pause = 1'b0;
    for (int k = 0; k < RD_DEPTH; k++) begin
      @(negedge clk);
      checks++;
      if (rd_dv !== 1'b1 || rd_data !== 32'hA500_0000 + DATA_W'(k)) begin
        failures++;
        $display("FAIL pause_write_beat %0d: got valid=%b data=%h, expected 1 %h",
                 k, rd_dv, rd_data, 32'hA500_0000 + DATA_W'(k));
      end
      step();
    end
    idle(2);
  endtask

  task automatic test_random();
    bit wg, rg, dv;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ew;
    for (int i = 0; i < 600; i++) begin
      reset_poweron = ($urandom_range(0, 99) == 0);
      wr_vld  = ($urandom_range(0, 1) == 1);
      rd_vld  = ($urandom_range(0, 1) == 1);
      pause   = ($urandom_range(0, 9) < 3);
      wr_addr = 24'h600 + ADDR_W'($urandom_range(0, 7));
      rd_addr = 24'h600 + ADDR_W'($urandom_range(0, 7));
      wr_data = $urandom;
      @(negedge clk);
      predict(wg, rg, dv);
      checks++;
      if (wr_rdy !== wg || rd_rdy !== rg || rd_dv !== dv) begin
        failures++;
        $display("FAIL rand_handshake cycle %0d: got wr=%b rd=%b valid=%b, expected %b %b %b",
                 i, wr_rdy, rd_rdy, rd_dv, wg, rg, dv);
      end
      if (dv) begin
        checks++;
        if (rd_data !== oq[0].data) begin
          failures++;
          $display("FAIL rand_data cycle %0d: got %h, expected %h", i, rd_data, oq[0].data);
        end
      end
      ea = wg ? wr_addr : (rg ? rd_addr : '0);
      ew = wg ? wr_data : '0;
      checks++;
      if (sram_en !== (wg | rg) || sram_we !== wg || sram_addr !== ea || sram_wdata !== ew) begin
        failures++;
        $display("FAIL rand_sram cycle %0d: got en=%b we=%b addr=%h wdata=%h, expected %b %b %h %h",
                 i, sram_en, sram_we, sram_addr, sram_wdata, wg | rg, wg, ea, ew);
      end
      step();
    end
    reset_poweron = 1'b0;
    idle(8);
  endtask

  initial begin
    reset_poweron = 1'b1;
    wr_vld = 1'b0; rd_vld = 1'b0; pause = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    test_reset();
    test_write_read();
    test_alternate();
    test_pause();
    test_wrap();
    test_reset_inflight();
    test_pause_writes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
